// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch front end: PC generation, SRAM issue, fetch-2 register
module if_stage #(
  parameter int          FS_TO_DS_BUS_WD = 34,
  parameter int          BR_BUS_WD       = 33,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [31:0]                flush_pc,
  input  logic [5:0]                 stall,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  output logic [FS_TO_DS_BUS_WD-1:0] fs2_to_ds_bus
);

  logic        started_q, started_d;
  logic [31:0] fs1_pc_q, fs1_pc_d;
  logic        fs2_valid_q, fs2_valid_d;
  logic        fs2_adef_q, fs2_adef_d;
  logic [31:0] fs2_pc_q, fs2_pc_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic        fs1_adef;
  logic        redirect;
  logic        unused_stall;

  assign br_taken     = br_bus[BR_BUS_WD-1];
  assign br_target    = br_bus[31:0];
  assign fs1_adef     = (fs1_pc_q[1:0] != 2'b00);
  assign redirect     = flush | br_taken;
  assign unused_stall = ^stall[5:2];

  // A redirected cycle never issues: its PC is already known to be wrong-path.
  assign inst_sram_en    = started_q & ~stall[0] & ~fs1_adef & ~redirect;
  assign inst_sram_addr  = fs1_pc_q;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_wdata = 32'h0;

  assign fs2_to_ds_bus = {fs2_valid_q, fs2_adef_q, fs2_pc_q};

  always_comb begin
    started_d = 1'b1;
    fs1_pc_d  = fs1_pc_q;
    if (started_q) begin
      if (flush) begin
        fs1_pc_d = flush_pc;
      end else if (br_taken) begin
        fs1_pc_d = br_target;
      end else if (!stall[0]) begin
        fs1_pc_d = fs1_pc_q + 32'd4;
      end
    end
  end

  always_comb begin
    fs2_valid_d = fs2_valid_q;
    fs2_adef_d  = fs2_adef_q;
    fs2_pc_d    = fs2_pc_q;
    if (redirect) begin
      fs2_valid_d = 1'b0;
    end else if (stall[0] && !stall[1]) begin
      fs2_valid_d = 1'b0;
    end else if (!stall[0]) begin
      fs2_valid_d = started_q;
      fs2_adef_d  = fs1_adef;
      fs2_pc_d    = fs1_pc_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      started_q   <= 1'b0;
      fs1_pc_q    <= RESET_PC;
      fs2_valid_q <= 1'b0;
      fs2_adef_q  <= 1'b0;
      fs2_pc_q    <= 32'h0;
    end else begin
      started_q   <= started_d;
      fs1_pc_q    <= fs1_pc_d;
      fs2_valid_q <= fs2_valid_d;
      fs2_adef_q  <= fs2_adef_d;
      fs2_pc_q    <= fs2_pc_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [33:0] fs2_to_ds_bus;

  int n_cmp = 0;
  int n_err = 0;

  if_stage #(
    .FS_TO_DS_BUS_WD(34),
    .BR_BUS_WD      (33),
    .RESET_PC       (32'h1c000000)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .stall          (stall),
    .br_bus         (br_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .fs2_to_ds_bus  (fs2_to_ds_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bus value for a valid, aligned entry.
  function automatic logic [33:0] vbus(input logic [31:0] pc);
    return {2'b10, pc};
  endfunction

  initial begin
    resetn   = 1'b0;
    flush    = 1'b0;
    flush_pc = 32'h0;
    stall    = 6'b0;
    br_bus   = 33'h0;
    tick();
    tick();
    check("rst_en", inst_sram_en, 1'b0);
    check("rst_bus", fs2_to_ds_bus, 34'h0);
    check("rst_addr", inst_sram_addr, 32'h1c000000);
    check("rst_we", inst_sram_we, 4'h0);
    check("rst_wdata", inst_sram_wdata, 32'h0);

    // Straight-line fetch after release
    resetn = 1'b1;
    #1;
    check("idle_en", inst_sram_en, 1'b0);
    check("idle_bus", fs2_to_ds_bus, 34'h0);
    tick();
    check("c2_en", inst_sram_en, 1'b1);
    check("c2_addr", inst_sram_addr, 32'h1c000000);
    check("c2_valid", fs2_to_ds_bus[33], 1'b0);
    tick();
    check("c3_addr", inst_sram_addr, 32'h1c000004);
    check("c3_bus", fs2_to_ds_bus, vbus(32'h1c000000));
    tick();
    check("c4_addr", inst_sram_addr, 32'h1c000008);
    check("c4_bus", fs2_to_ds_bus, vbus(32'h1c000004));
    tick();
    tick();
    check("pre_br_addr", inst_sram_addr, 32'h1c000010);
    check("pre_br_bus", fs2_to_ds_bus, vbus(32'h1c00000c));

    // Branch redirect
    br_bus = {1'b1, 32'h1c000100};
    #1;
    check("br_en_off", inst_sram_en, 1'b0);
    tick();
    br_bus = 33'h0;
    #1;
    check("br_addr", inst_sram_addr, 32'h1c000100);
    check("br_en", inst_sram_en, 1'b1);
    check("br_kill", fs2_to_ds_bus[33], 1'b0);
    tick();
    check("br_bus", fs2_to_ds_bus, vbus(32'h1c000100));
    tick();
    check("br_next_addr", inst_sram_addr, 32'h1c000108);
    check("br_next_bus", fs2_to_ds_bus, vbus(32'h1c000104));

    // Full stall for three edges
    stall = 6'b000011;
    #1;
    check("st_en", inst_sram_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_addr", inst_sram_addr, 32'h1c000108);
      check("st_bus", fs2_to_ds_bus, vbus(32'h1c000104));
    end
    stall = 6'b0;
    #1;
    check("st_rel_en", inst_sram_en, 1'b1);
    tick();
    check("st_rel_addr", inst_sram_addr, 32'h1c00010c);
    check("st_rel_bus", fs2_to_ds_bus, vbus(32'h1c000108));

    // PC-only stall inserts one bubble
    stall = 6'b000001;
    #1;
    check("bub_en", inst_sram_en, 1'b0);
    tick();
    stall = 6'b0;
    #1;
    check("bub_valid", fs2_to_ds_bus[33], 1'b0);
    check("bub_addr", inst_sram_addr, 32'h1c00010c);
    check("bub_en_on", inst_sram_en, 1'b1);
    tick();
    check("bub_after", fs2_to_ds_bus, vbus(32'h1c00010c));
    check("bub_after_addr", inst_sram_addr, 32'h1c000110);

    // Flush beats branch; misaligned target becomes ADEF
    flush    = 1'b1;
    flush_pc = 32'h1c000802;
    br_bus   = {1'b1, 32'h1c000500};
    #1;
    check("fl_en_off", inst_sram_en, 1'b0);
    tick();
    flush  = 1'b0;
    br_bus = 33'h0;
    #1;
    check("fl_addr", inst_sram_addr, 32'h1c000802);
    check("fl_adef_en", inst_sram_en, 1'b0);
    check("fl_kill", fs2_to_ds_bus[33], 1'b0);
    tick();
    check("fl_adef_bus", fs2_to_ds_bus, {2'b11, 32'h1c000802});

    // Flush during full stall still redirects
    stall    = 6'b000011;
    flush    = 1'b1;
    flush_pc = 32'h1c000040;
    tick();
    flush = 1'b0;
    stall = 6'b0;
    #1;
    check("flst_addr", inst_sram_addr, 32'h1c000040);
    check("flst_en", inst_sram_en, 1'b1);
    check("flst_kill", fs2_to_ds_bus[33], 1'b0);
    tick();
    check("flst_bus", fs2_to_ds_bus, vbus(32'h1c000040));

    // Asynchronous reset mid-stream
    #2;
    resetn = 1'b0;
    #1;
    check("ar_en", inst_sram_en, 1'b0);
    check("ar_bus", fs2_to_ds_bus, 34'h0);
    check("ar_addr", inst_sram_addr, 32'h1c000000);
    tick();
    resetn = 1'b1;
    #1;
    check("ar_idle_en", inst_sram_en, 1'b0);
    tick();
    check("ar_re_en", inst_sram_en, 1'b1);
    check("ar_re_addr", inst_sram_addr, 32'h1c000000);
    tick();
    check("ar_re_bus", fs2_to_ds_bus, vbus(32'h1c000000));

    // PC wraps modulo 2^32
    flush    = 1'b1;
    flush_pc = 32'hfffffffc;
    tick();
    flush = 1'b0;
    #1;
    check("wr_addr", inst_sram_addr, 32'hfffffffc);
    tick();
    check("wr_addr0", inst_sram_addr, 32'h0);
    check("wr_bus", fs2_to_ds_bus, vbus(32'hfffffffc));
    check("wr_en", inst_sram_en, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
